// File: rtl/prio_arbiter_pkg.sv
// Shared types for the priority arbiter: FSM states, compare-tree candidate and id-width helper.
package prio_arbiter_pkg;

  localparam int MaxIdW  = 8;
  localparam int MaxKeyW = 33;

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  // Candidate fields are sized for the largest supported configuration and zero-extended.
  typedef struct packed {
    logic [MaxIdW-1:0]  id;
    logic [MaxKeyW-1:0] key;
  } cand_t;

  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/prio_max_tree.sv
// Log-depth max-reduction tree: returns the lowest index holding the largest valid key.
module prio_max_tree
  import prio_arbiter_pkg::*;
#(
  parameter int N     = 4,
  parameter int KEY_W = 5,
  parameter int ID_W  = 2
) (
  input  logic [N-1:0]            valid_i,
  input  logic [N-1:0][KEY_W-1:0] key_i,
  output logic                    found_o,
  output logic [ID_W-1:0]         idx_o
);

  localparam int Leaves = 1 << $clog2(N);

  logic  nodeValid [2*Leaves-1];
  cand_t node      [2*Leaves-1];

  for (genvar i = 0; i < Leaves; i++) begin : g_leaf
    if (i < N) begin : g_real
      assign nodeValid[Leaves-1+i] = valid_i[i];
      assign node[Leaves-1+i]      = '{id: MaxIdW'(i), key: MaxKeyW'(key_i[i])};
    end else begin : g_pad
      assign nodeValid[Leaves-1+i] = 1'b0;
      assign node[Leaves-1+i]      = '0;
    end
  end

  // Left subtrees cover lower indices, so ">=" keeps the lower index on a tie.
  for (genvar k = 0; k < Leaves - 1; k++) begin : g_node
    logic takeLeft;
    assign takeLeft = nodeValid[2*k+1] &&
                      (!nodeValid[2*k+2] || (node[2*k+1].key >= node[2*k+2].key));
    assign nodeValid[k] = nodeValid[2*k+1] | nodeValid[2*k+2];
    assign node[k]      = takeLeft ? node[2*k+1] : node[2*k+2];
  end

  assign found_o = nodeValid[0];
  assign idx_o   = node[0].id[ID_W-1:0];

endmodule

// File: rtl/prio_arbiter.sv
// Registered priority arbiter with empty mask, optional round-robin tie-break and aging,
// holding each grant under a valid/ready handshake.
module prio_arbiter
  import prio_arbiter_pkg::*;
#(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int PRIORITY_SIZE    = 4,
  parameter int TIE_BREAK_RR     = 1,
  parameter int AGING_THRESHOLD  = 0
) (
  input  logic                                              clock,
  input  logic                                              reset,
  input  logic [NUMBER_OF_QUEUES-1:0][PRIORITY_SIZE-1:0]    priorities,
  input  logic [NUMBER_OF_QUEUES-1:0]                       empty,
  input  logic                                              grant_ready,
  output logic                                              grant_valid,
  output logic [$clog2(NUMBER_OF_QUEUES)-1:0]               selection,
  output logic [PRIORITY_SIZE-1:0]                          selected_priority
);

  localparam int N    = NUMBER_OF_QUEUES;
  localparam int IdW  = idWidth(N);
  localparam int KeyW = PRIORITY_SIZE + 1;
  localparam int CntW = (AGING_THRESHOLD > 0) ? $clog2(AGING_THRESHOLD + 1) : 1;
  localparam logic [IdW-1:0] LastId = IdW'(N - 1);

  state_e                     state_q;
  logic                       valid_q;
  logic [IdW-1:0]             selection_q;
  logic [PRIORITY_SIZE-1:0]   selPrio_q;
  logic [IdW-1:0]             rrPtr_q;
  logic [N-1:0][CntW-1:0]     waitCnt_q, waitCnt_d;

  logic                       accept;
  logic [N-1:0]               eligible, aged, rotValid;
  logic [N-1:0][KeyW-1:0]     key, rotKey;
  logic                       found;
  logic [IdW-1:0]             rotWinner, winner;

  // Maps a rotated tree position back to a queue id; identity in fixed-priority mode.
  function automatic int srcOf(input logic [IdW-1:0] ptr, input int j);
    return (TIE_BREAK_RR != 0) ? (int'(ptr) + 1 + j) % N : j;
  endfunction

  assign accept = (state_q == GRANT) && grant_ready;

  // The accepted queue is masked because its empty flag only reflects the pop next cycle.
  always_comb begin
    eligible = '0;
    aged     = '0;
    key      = '0;
    for (int i = 0; i < N; i++) begin
      aged[i]     = (AGING_THRESHOLD > 0) && (waitCnt_q[i] == CntW'(AGING_THRESHOLD));
      eligible[i] = !empty[i] && !(accept && (selection_q == IdW'(i)));
      key[i]      = {aged[i], priorities[i]};
    end
  end

  always_comb begin
    rotValid = '0;
    rotKey   = '0;
    for (int j = 0; j < N; j++) begin
      rotValid[j] = eligible[srcOf(rrPtr_q, j)];
      rotKey[j]   = key[srcOf(rrPtr_q, j)];
    end
  end

  prio_max_tree #(
    .N     (N),
    .KEY_W (KeyW),
    .ID_W  (IdW)
  ) u_tree (
    .valid_i (rotValid),
    .key_i   (rotKey),
    .found_o (found),
    .idx_o   (rotWinner)
  );

  assign winner = IdW'(srcOf(rrPtr_q, int'(rotWinner)));

  always_comb begin
    waitCnt_d = waitCnt_q;
    for (int i = 0; i < N; i++) begin
      if ((AGING_THRESHOLD == 0) || empty[i] || (accept && (selection_q == IdW'(i)))) begin
        waitCnt_d[i] = '0;
      end else if (waitCnt_q[i] != CntW'(AGING_THRESHOLD)) begin
        waitCnt_d[i] = waitCnt_q[i] + 1'b1;
      end
    end
  end

  // Accept wins over withdraw; a held grant is never preempted by priority changes.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      selection_q <= '0;
      selPrio_q   <= '0;
      rrPtr_q     <= LastId;
      waitCnt_q   <= '0;
    end else begin
      waitCnt_q <= waitCnt_d;
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_q     <= GRANT;
            valid_q     <= 1'b1;
            selection_q <= winner;
            selPrio_q   <= priorities[winner];
          end
        end
        GRANT: begin
          if (grant_ready) begin
            rrPtr_q <= selection_q;
            if (found) begin
              selection_q <= winner;
              selPrio_q   <= priorities[winner];
            end else begin
              state_q <= IDLE;
              valid_q <= 1'b0;
            end
          end else if (empty[selection_q]) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign grant_valid       = valid_q;
  assign selection         = selection_q;
  assign selected_priority = selPrio_q;

endmodule

// File: tb/tb_prio_arbiter.sv
// Bench for prio_arbiter: three configurations (fixed, round-robin, round-robin with aging)
// driven together and compared every cycle against a queue-level reference model.
module tb_prio_arbiter;

  localparam int NQ = 4;
  localparam int NI = 3;

  typedef logic [NQ-1:0][3:0] prio_t;

  logic        clock = 1'b0;
  logic        reset;
  prio_t       priorities;
  logic [NQ-1:0] emptyIn;
  logic        grantReady;

  logic        gv  [NI];
  logic [1:0]  sel [NI];
  logic [3:0]  sp  [NI];

  int checks = 0;
  int errors = 0;

  bit mValid [NI];
  int mSel   [NI];
  int mPrio  [NI];
  int mLast  [NI];
  int mCnt   [NI][NQ];

  always #5 clock = ~clock;

  prio_arbiter #(.NUMBER_OF_QUEUES(4), .PRIORITY_SIZE(4), .TIE_BREAK_RR(0), .AGING_THRESHOLD(0)) dutFixed (
    .clock(clock), .reset(reset), .priorities(priorities), .empty(emptyIn), .grant_ready(grantReady),
    .grant_valid(gv[0]), .selection(sel[0]), .selected_priority(sp[0]));

  prio_arbiter #(.NUMBER_OF_QUEUES(4), .PRIORITY_SIZE(4), .TIE_BREAK_RR(1), .AGING_THRESHOLD(0)) dutRr (
    .clock(clock), .reset(reset), .priorities(priorities), .empty(emptyIn), .grant_ready(grantReady),
    .grant_valid(gv[1]), .selection(sel[1]), .selected_priority(sp[1]));

  prio_arbiter #(.NUMBER_OF_QUEUES(4), .PRIORITY_SIZE(4), .TIE_BREAK_RR(1), .AGING_THRESHOLD(4)) dutAged (
    .clock(clock), .reset(reset), .priorities(priorities), .empty(emptyIn), .grant_ready(grantReady),
    .grant_valid(gv[2]), .selection(sel[2]), .selected_priority(sp[2]));

  function automatic bit rrOf(input int k);
    return k != 0;
  endfunction

  function automatic int agOf(input int k);
    return (k == 2) ? 4 : 0;
  endfunction

  function automatic prio_t pr(input int q0, input int q1, input int q2, input int q3);
    return {4'(q3), 4'(q2), 4'(q1), 4'(q0)};
  endfunction

  // Reference: scan queues in search order, keep the first strictly larger key.
  task automatic stepModels();
    for (int k = 0; k < NI; k++) begin
      bit acc, wd;
      int best, bestKey, q, key, ag;
      ag = agOf(k);
      if (reset) begin
        mValid[k] = 1'b0;
        mSel[k]   = 0;
        mPrio[k]  = 0;
        mLast[k]  = NQ - 1;
        for (int i = 0; i < NQ; i++) mCnt[k][i] = 0;
      end else begin
        acc     = mValid[k] && grantReady;
        wd      = mValid[k] && !grantReady && emptyIn[mSel[k]];
        best    = -1;
        bestKey = -1;
        if (!mValid[k] || acc) begin
          for (int s = 0; s < NQ; s++) begin
            q = rrOf(k) ? (mLast[k] + 1 + s) % NQ : s;
            if (!emptyIn[q] && !(acc && q == mSel[k])) begin
              key = int'(priorities[q]) + ((ag > 0 && mCnt[k][q] == ag) ? 16 : 0);
              if (key > bestKey) begin
                bestKey = key;
                best    = q;
              end
            end
          end
        end
        for (int i = 0; i < NQ; i++) begin
          if (emptyIn[i] || (acc && mSel[k] == i)) mCnt[k][i] = 0;
          else if (mCnt[k][i] < ag) mCnt[k][i] = mCnt[k][i] + 1;
        end
        if (acc) mLast[k] = mSel[k];
        if (!mValid[k] || acc) begin
          if (best >= 0) begin
            mValid[k] = 1'b1;
            mSel[k]   = best;
            mPrio[k]  = int'(priorities[best]);
          end else begin
            mValid[k] = 1'b0;
          end
        end else if (wd) begin
          mValid[k] = 1'b0;
        end
      end
    end
  endtask

  task automatic checkOutput();
    for (int k = 0; k < NI; k++) begin
      checks++;
      assert (gv[k] === mValid[k]) else begin
        errors++;
        $error("FAIL modelValid[%0d]: got %b expected %b", k, gv[k], mValid[k]);
      end
      if (mValid[k]) begin
        checks++;
        assert (sel[k] === 2'(mSel[k])) else begin
          errors++;
          $error("FAIL modelSel[%0d]: got %0d expected %0d", k, sel[k], mSel[k]);
        end
        checks++;
        assert (sp[k] === 4'(mPrio[k])) else begin
          errors++;
          $error("FAIL modelPrio[%0d]: got %0d expected %0d", k, sp[k], mPrio[k]);
        end
      end
    end
  endtask

  task automatic checkLiteral(input string tag, input int k, input bit expValid, input int expSel, input bit withSel);
    checks++;
    assert (gv[k] === expValid) else begin
      errors++;
      $error("FAIL %s valid[%0d]: got %b expected %b", tag, k, gv[k], expValid);
    end
    if (withSel) begin
      checks++;
      assert (sel[k] === 2'(expSel)) else begin
        errors++;
        $error("FAIL %s sel[%0d]: got %0d expected %0d", tag, k, sel[k], expSel);
      end
    end
  endtask

  task automatic applyStimulus(input prio_t p, input logic [NQ-1:0] e, input logic r, input logic rst);
    priorities = p;
    emptyIn    = e;
    grantReady = r;
    reset      = rst;
    @(posedge clock);
    stepModels();
    #1;
    checkOutput();
  endtask

  initial begin
    int gap;
    reset      = 1'b1;
    grantReady = 1'b0;
    emptyIn    = '1;
    priorities = '0;

    applyStimulus(pr(0, 0, 0, 0), 4'b1111, 1'b0, 1'b1);
    applyStimulus(pr(0, 0, 0, 0), 4'b1111, 1'b0, 1'b1);
    for (int k = 0; k < NI; k++) checkLiteral("resetState", k, 1'b0, 0, 1'b1);

    for (int c = 0; c < 5; c++) begin
      applyStimulus(pr(5, 5, 5, 5), 4'b0000, 1'b1, 1'b0);
      checkLiteral("rrOrder", 1, 1'b1, c % 4, 1'b1);
    end

    for (int c = 0; c < 3; c++) begin
      applyStimulus(pr(5, 5, 5, 5), 4'b1111, 1'b1, 1'b0);
      for (int k = 0; k < NI; k++) checkLiteral("allEmpty", k, 1'b0, 0, 1'b0);
    end

    for (int c = 0; c < 4; c++) begin
      applyStimulus(pr(5, 5, 5, 5), 4'b1101, 1'b1, 1'b0);
      for (int k = 0; k < NI; k++) checkLiteral("singleQueue", k, (c % 2) == 0, 1, (c % 2) == 0);
    end

    for (int c = 0; c < 6; c++) begin
      applyStimulus(pr(3, 9, 9, 1), 4'b0000, 1'b1, 1'b0);
      checkLiteral("fixedPrio", 0, 1'b1, (c % 2 == 0) ? 1 : 2, 1'b1);
    end

    applyStimulus(pr(3, 9, 9, 1), 4'b1111, 1'b1, 1'b0);
    for (int k = 0; k < NI; k++) checkLiteral("drainIdle", k, 1'b0, 0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      applyStimulus(pr(3, 9, 9, 1), 4'b1011, 1'b0, 1'b0);
      for (int k = 0; k < NI; k++) checkLiteral("holdGrant", k, 1'b1, 2, 1'b1);
    end
    for (int c = 0; c < 2; c++) begin
      applyStimulus(pr(15, 9, 9, 1), 4'b1010, 1'b0, 1'b0);
      for (int k = 0; k < NI; k++) checkLiteral("noPreempt", k, 1'b1, 2, 1'b1);
    end
    applyStimulus(pr(15, 9, 9, 1), 4'b1110, 1'b0, 1'b0);
    for (int k = 0; k < NI; k++) checkLiteral("withdraw", k, 1'b0, 0, 1'b0);

    applyStimulus(pr(0, 0, 0, 7), 4'b1111, 1'b1, 1'b0);
    gap = 0;
    for (int c = 0; c < 30; c++) begin
      applyStimulus(pr(0, 0, 0, 7), 4'b0110, 1'b1, 1'b0);
      if (gv[2] === 1'b1 && sel[2] === 2'd0) gap = 0;
      else gap++;
      checks++;
      assert (gap <= 5) else begin
        errors++;
        $error("FAIL agingGap: waited %0d cycles, limit 5", gap);
      end
    end

    applyStimulus(pr(5, 5, 5, 5), 4'b0000, 1'b1, 1'b0);
    applyStimulus(pr(5, 5, 5, 5), 4'b0000, 1'b1, 1'b0);
    applyStimulus(pr(5, 5, 5, 5), 4'b0000, 1'b1, 1'b1);
    for (int k = 0; k < NI; k++) begin
      checkLiteral("resetMidGrant", k, 1'b0, 0, 1'b1);
      checks++;
      assert (sp[k] === 4'd0) else begin
        errors++;
        $error("FAIL resetMidGrant prio[%0d]: got %0d expected 0", k, sp[k]);
      end
    end
    applyStimulus(pr(5, 5, 5, 5), 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < NI; k++) checkLiteral("postResetTie", k, 1'b1, 0, 1'b1);

    for (int c = 0; c < 400; c++) begin
      applyStimulus(prio_t'($urandom), 4'($urandom & $urandom),
                    $urandom_range(3) != 0, $urandom_range(63) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
